// File: rtl/sfft_sequencer.sv
// sfft_sequencer: paces the SFFT pipeline. It takes one audio sample at a time,
// pulses the pipeline's advance input, waits for the spectrum to settle and
// publishes a frame to the peak finder every HOP samples once the window is full.
//
// Optional feature macro: SFFT_SEQ_TIMEOUT_EN adds a SETTLE watchdog that
// raises a sticky timeout_err. Without it, timeout_err is tied low.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a sample; sample_ready high
// ADVANCE | one-cycle advance pulse to the pipeline; settle timer loaded
// SETTLE  | counting down the settle time, then waiting for OutputValid
// PUBLISH | frame_valid high until the downstream accepts the spectrum
module sfft_sequencer #(
  parameter int SAMPLE_WIDTH   = 24,
  parameter int NFFT           = 8,
  parameter int HOP            = 4,
  parameter int SETTLE_CYCLES  = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [SAMPLE_WIDTH-1:0] sfft_sample,
  output logic                    sfft_advance,
  input  logic                    sfft_output_valid,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [15:0]             frame_index,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    SETTLE  = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  localparam int FW = $clog2(NFFT + 1);
  localparam int HW = $clog2(HOP + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [FW-1:0] FILL_FULL   = FW'(NFFT);
  localparam logic [FW-1:0] FILL_LAST   = FW'(NFFT - 1);
  localparam logic [HW-1:0] HOP_FULL    = HW'(HOP);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  state_t          state;
  logic [FW-1:0]   fill_cnt;
  logic [HW-1:0]   hop_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            settle_done;

`ifdef SFFT_SEQ_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WD_LOAD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wd_cnt;
`else
  // No watchdog in this build; the parameter only keeps the interface uniform.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  // Handshake and pulse outputs are pure decodes of the state register.
  assign sample_ready = (state == IDLE);
  assign sfft_advance = (state == ADVANCE);
  assign frame_valid  = (state == PUBLISH);
  assign settle_done  = (settle_cnt == '0) && sfft_output_valid;

  // Sequencer FSM, counters and registered sample/frame outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      hop_cnt     <= '0;
      settle_cnt  <= '0;
      sfft_sample <= '0;
      frame_index <= '0;
`ifdef SFFT_SEQ_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid) begin
            sfft_sample <= sample_in;
            if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + 1'b1;
            // The sample that completes the window always closes a hop, so
            // the first frame lands on sample NFFT whatever HOP is.
            if (fill_cnt == FILL_LAST)
              hop_cnt <= HOP_FULL;
            else if (hop_cnt != HOP_FULL)
              hop_cnt <= hop_cnt + 1'b1;
            state <= ADVANCE;
          end
        end

        ADVANCE: begin
          settle_cnt <= SETTLE_LOAD;
`ifdef SFFT_SEQ_TIMEOUT_EN
          wd_cnt     <= WD_LOAD;
`endif
          state      <= SETTLE;
        end

        SETTLE: begin
          if (settle_done) begin
            if (fill_cnt == FILL_FULL && hop_cnt == HOP_FULL) begin
              hop_cnt <= '0;
              state   <= PUBLISH;
            end else begin
              if (fill_cnt != FILL_FULL) hop_cnt <= '0;
              state <= IDLE;
            end
          end else begin
            if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
`ifdef SFFT_SEQ_TIMEOUT_EN
            // Give up on this spectrum; hop_cnt is kept so the hop still completes.
            if (wd_cnt == '0) begin
              timeout_err <= 1'b1;
              state       <= IDLE;
            end else begin
              wd_cnt <= wd_cnt - 1'b1;
            end
`endif
          end
        end

        PUBLISH: begin
          if (frame_ready) begin
            frame_index <= frame_index + 16'd1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfft_sequencer.sv
// Self-checking bench for sfft_sequencer: scoreboarded samples and frames,
// settle timing, backpressure, settle extension, watchdog and async reset.
module tb_sfft_sequencer;

  localparam int SAMPLE_WIDTH   = 24;
  localparam int NFFT           = 8;
  localparam int HOP            = 4;
  localparam int SETTLE_CYCLES  = 30;
  localparam int TIMEOUT_CYCLES = 255;

  logic                    clk;
  logic                    reset;
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid;
  logic                    sample_ready;
  logic [SAMPLE_WIDTH-1:0] sfft_sample;
  logic                    sfft_advance;
  logic                    sfft_output_valid;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [15:0]             frame_index;
  logic                    timeout_err;

  sfft_sequencer #(
    .SAMPLE_WIDTH  (SAMPLE_WIDTH),
    .NFFT          (NFFT),
    .HOP           (HOP),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .sample_ready     (sample_ready),
    .sfft_sample      (sfft_sample),
    .sfft_advance     (sfft_advance),
    .sfft_output_valid(sfft_output_valid),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .frame_index      (frame_index),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [SAMPLE_WIDTH-1:0] sample_q[$];
  logic [15:0]             frame_q[$];
  int n_samples  = 0;
  int exp_frames = 0;
  int acc_cyc    = 0;

  int   cyc        = 0;
  int   adv_cnt    = 0;
  int   fv_cycles  = 0;
  int   fv_rises   = 0;
  logic fv_prev    = 1'b0;

  // Activity counters sampled away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sfft_advance) adv_cnt <= adv_cnt + 1;
    if (frame_valid) fv_cycles <= fv_cycles + 1;
    if (frame_valid && !fv_prev) fv_rises <= fv_rises + 1;
    fv_prev <= frame_valid;
  end

  // Drives one sample through the handshake; returns at the negedge after acceptance
  // and records the expected sample and any frame the window/hop model predicts.
  task automatic send_sample(input logic [SAMPLE_WIDTH-1:0] v);
    int w;
    w = 0;
    sample_in    = v;
    sample_valid = 1'b1;
    while (!sample_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!sample_ready) begin
      checks++;
      errors++;
      $display("FAIL send_sample: sample_ready=%0b required 1 within 2000 cycles", sample_ready);
      sample_valid = 1'b0;
    end else begin
      @(negedge clk);
      sample_valid = 1'b0;
      acc_cyc = cyc;
      sample_q.push_back(v);
      n_samples++;
      if (n_samples >= NFFT && ((n_samples - NFFT) % HOP) == 0) begin
        exp_frames++;
        frame_q.push_back(16'(exp_frames));
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    sfft_output_valid = 1'b1;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: sample_ready=%0b required 1", sample_ready);
    end
    checks++;
    if (sfft_advance !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: advance=%0b frame_valid=%0b required 0/0", sfft_advance, frame_valid);
    end
    checks++;
    if (sfft_sample !== '0 || frame_index !== 16'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: sfft_sample=%0d frame_index=%0d timeout_err=%0b required 0/0/0",
               sfft_sample, frame_index, timeout_err);
    end
  endtask

  task automatic test_single_sample;
    logic [SAMPLE_WIDTH-1:0] exp_s;
    int a0, f0, low;
    a0 = adv_cnt;
    f0 = fv_cycles;
    send_sample(24'd61);
    exp_s = sample_q.pop_front();
    checks++;
    if (sfft_sample !== exp_s || sfft_advance !== 1'b1) begin
      errors++;
      $display("FAIL single_sample: sfft_sample=%0d advance=%0b required %0d/1", sfft_sample, sfft_advance, exp_s);
    end
    low = 0;
    while (!sample_ready && low < 200) begin
      low++;
      @(negedge clk);
    end
    checks++;
    if (low != SETTLE_CYCLES + 1) begin
      errors++;
      $display("FAIL single_ready_low: low cycles=%0d required %0d", low, SETTLE_CYCLES + 1);
    end
    checks++;
    if (adv_cnt - a0 != 1 || fv_cycles != f0) begin
      errors++;
      $display("FAIL single_pulses: advances=%0d frame_valid cycles=%0d required 1/0", adv_cnt - a0, fv_cycles - f0);
    end
  endtask

  task automatic test_window_fill;
    logic [SAMPLE_WIDTH-1:0] d[7] = '{24'd77, 24'd90, 24'd6, 24'd33, 24'd23, 24'd85, 24'd11};
    logic [SAMPLE_WIDTH-1:0] exp_s;
    logic [15:0] exp_f;
    int r0, w;
    r0 = fv_rises;
    for (int i = 0; i < 7; i++) begin
      send_sample(d[i]);
      exp_s = sample_q.pop_front();
      checks++;
      if (sfft_sample !== exp_s || sfft_advance !== 1'b1) begin
        errors++;
        $display("FAIL fill_sample_%0d: sfft_sample=%0d advance=%0b required %0d/1", i + 2, sfft_sample, sfft_advance, exp_s);
      end
    end
    checks++;
    if (fv_rises != r0) begin
      errors++;
      $display("FAIL fill_early_frame: frames before sample 8=%0d required 0", fv_rises - r0);
    end
    w = 0;
    while (!frame_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (frame_valid !== 1'b1 || frame_index !== 16'd0) begin
      errors++;
      $display("FAIL fill_frame: frame_valid=%0b frame_index=%0d required 1/0", frame_valid, frame_index);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    exp_f = frame_q.pop_front();
    checks++;
    if (frame_index !== exp_f || frame_valid !== 1'b0 || fv_rises - r0 != 1) begin
      errors++;
      $display("FAIL fill_index: frame_index=%0d frame_valid=%0b frames=%0d required %0d/0/1",
               frame_index, frame_valid, fv_rises - r0, exp_f);
    end
  endtask

  task automatic test_hop_backpressure;
    logic [SAMPLE_WIDTH-1:0] exp_s;
    logic [15:0] exp_f;
    int r0, w, bad;
    r0 = fv_rises;
    for (int i = 0; i < 4; i++) begin
      send_sample(24'(40 + i));
      exp_s = sample_q.pop_front();
      checks++;
      if (sfft_sample !== exp_s) begin
        errors++;
        $display("FAIL hop_sample_%0d: sfft_sample=%0d required %0d", i, sfft_sample, exp_s);
      end
    end
    checks++;
    if (fv_rises != r0) begin
      errors++;
      $display("FAIL hop_early_frame: frames before hop end=%0d required 0", fv_rises - r0);
    end
    w = 0;
    while (!frame_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    // A held sample must wait out the stalled frame, then be taken.
    sample_in = 24'd99;
    sample_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_valid !== 1'b1 || sample_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hop_backpressure: bad cycles=%0d required 0", bad);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    exp_f = frame_q.pop_front();
    checks++;
    if (frame_index !== exp_f || frame_valid !== 1'b0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL hop_index: frame_index=%0d frame_valid=%0b ready=%0b required %0d/0/1",
               frame_index, frame_valid, sample_ready, exp_f);
    end
    sample_q.push_back(24'd99);
    n_samples++;
    @(negedge clk);
    sample_valid = 1'b0;
    exp_s = sample_q.pop_front();
    checks++;
    if (sfft_sample !== exp_s || sfft_advance !== 1'b1) begin
      errors++;
      $display("FAIL hop_held_sample: sfft_sample=%0d advance=%0b required %0d/1", sfft_sample, sfft_advance, exp_s);
    end
  endtask

  task automatic test_settle_wait;
    logic [SAMPLE_WIDTH-1:0] exp_s;
    int bad;
    send_sample(24'd55);
    exp_s = sample_q.pop_front();
    checks++;
    if (sfft_sample !== exp_s) begin
      errors++;
      $display("FAIL settle_sample: sfft_sample=%0d required %0d", sfft_sample, exp_s);
    end
    sfft_output_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sample_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL settle_hold: early exit cycles=%0d required 0", bad);
    end
    sfft_output_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (sample_ready !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL settle_exit: ready=%0b frame_valid=%0b required 1/0", sample_ready, frame_valid);
    end
  endtask

  task automatic test_watchdog;
    logic [SAMPLE_WIDTH-1:0] exp_s;
    logic [15:0] exp_f;
    int low, w;
    send_sample(24'd66);
    exp_s = sample_q.pop_front();
    checks++;
    if (sfft_sample !== exp_s) begin
      errors++;
      $display("FAIL wd_sample: sfft_sample=%0d required %0d", sfft_sample, exp_s);
    end
    sfft_output_valid = 1'b0;
    low = 0;
    while (!sample_ready && low < 300) begin
      @(negedge clk);
      low++;
    end
`ifdef SFFT_SEQ_TIMEOUT_EN
    checks++;
    if (low != TIMEOUT_CYCLES + 1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL wd_trip: cycles to idle=%0d timeout_err=%0b required %0d/1", low, timeout_err, TIMEOUT_CYCLES + 1);
    end
`else
    checks++;
    if (sample_ready !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_absent: ready=%0b timeout_err=%0b required 0/0", sample_ready, timeout_err);
    end
`endif
    sfft_output_valid = 1'b1;
    send_sample(24'd67);
    exp_s = sample_q.pop_front();
    checks++;
    if (sfft_sample !== exp_s) begin
      errors++;
      $display("FAIL wd_next_sample: sfft_sample=%0d required %0d", sfft_sample, exp_s);
    end
    w = 0;
    while (!frame_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    exp_f = frame_q.pop_front();
    checks++;
`ifdef SFFT_SEQ_TIMEOUT_EN
    if (frame_index !== exp_f || timeout_err !== 1'b1) begin
`else
    if (frame_index !== exp_f || timeout_err !== 1'b0) begin
`endif
      errors++;
      $display("FAIL wd_after: frame_index=%0d timeout_err=%0b required index %0d", frame_index, timeout_err, exp_f);
    end
  endtask

  task automatic test_reset_mid_flight;
    logic [SAMPLE_WIDTH-1:0] exp_s;
    send_sample(24'd70);
    exp_s = sample_q.pop_front();
    checks++;
    if (sfft_sample !== exp_s) begin
      errors++;
      $display("FAIL rst_settle_sample: sfft_sample=%0d required %0d", sfft_sample, exp_s);
    end
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (sample_ready !== 1'b1 || sfft_advance !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_settle: ready=%0b advance=%0b frame_valid=%0b required 1/0/0",
               sample_ready, sfft_advance, frame_valid);
    end
    checks++;
    if (sfft_sample !== '0 || frame_index !== 16'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_regs: sfft_sample=%0d frame_index=%0d timeout_err=%0b required 0/0/0",
               sfft_sample, frame_index, timeout_err);
    end
    n_samples = 0;
    exp_frames = 0;
    sample_q.delete();
    frame_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_sample(24'd71);
    checks++;
    if (sfft_advance !== 1'b1) begin
      errors++;
      $display("FAIL rst_adv_pre: advance=%0b required 1", sfft_advance);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (sfft_advance !== 1'b0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_advance: advance=%0b ready=%0b required 0/1", sfft_advance, sample_ready);
    end
    n_samples = 0;
    exp_frames = 0;
    sample_q.delete();
    frame_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [SAMPLE_WIDTH-1:0] exp_s;
    logic [15:0] exp_f;
    int t[8];
    int r0, c0, w;
    frame_ready = 1'b1;
    sfft_output_valid = 1'b1;
    r0 = fv_rises;
    c0 = fv_cycles;
    for (int i = 0; i < 8; i++) begin
      send_sample(24'(i * 3 + 1));
      t[i] = acc_cyc;
      exp_s = sample_q.pop_front();
      checks++;
      if (sfft_sample !== exp_s) begin
        errors++;
        $display("FAIL b2b_sample_%0d: sfft_sample=%0d required %0d", i, sfft_sample, exp_s);
      end
    end
    checks++;
    if (t[2] - t[1] != SETTLE_CYCLES + 2) begin
      errors++;
      $display("FAIL b2b_period: sample period=%0d required %0d", t[2] - t[1], SETTLE_CYCLES + 2);
    end
    w = 0;
    while (!sample_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    exp_f = frame_q.pop_front();
    checks++;
    if (fv_cycles - c0 != 1 || fv_rises - r0 != 1 || frame_index !== exp_f) begin
      errors++;
      $display("FAIL b2b_frame: frame_valid cycles=%0d frames=%0d frame_index=%0d required 1/1/%0d",
               fv_cycles - c0, fv_rises - r0, frame_index, exp_f);
    end
    frame_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_sample;
    test_window_fill;
    test_hop_backpressure;
    test_settle_wait;
    test_watchdog;
    test_reset_mid_flight;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time exceeded bound");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/sfft_sequencer.md
# sfft_sequencer

Controller that sequences the SFFT pipeline. It accepts audio samples from the codec side over a valid/ready handshake and presents each sample to the pipeline's sample input. It issues the single-cycle advance pulse, waits for the recomputation to settle, and publishes completed spectra to the downstream peak finder every HOP samples. It sits between the audio sample source and `SFFT_Pipeline`, and replaces the hand-timed advance sequencing used in simulation.

## Interface
- SAMPLE_WIDTH, 24, sample width; equals `SFFT_INPUT_WIDTH.
- NFFT, 8, window length; the first NFFT samples after reset only fill the window.
- HOP, 4, samples per published frame (1..NFFT).
- SETTLE_CYCLES, 30, minimum cycles from the advance pulse until the spectrum may be trusted (≥1).
- TIMEOUT_CYCLES, 255, watchdog limit; used only with SFFT_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sample_in  in  SAMPLE_WIDTH  audio sample.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  sequencer can accept a sample.
- sfft_sample  out  SAMPLE_WIDTH  to SFFT_Pipeline.SampleAmplitudeIn.
- sfft_advance  out  1  to SFFT_Pipeline.advanceSignal.
- sfft_output_valid  in  1  from SFFT_Pipeline.OutputValid.
- frame_valid  out  1  new spectrum is available on SFFT_Out.
- frame_ready  in  1  downstream has consumed the frame.
- frame_index  out  16  count of published frames; wraps modulo 2^16.
- timeout_err  out  1  sticky watchdog error.

## Operation
- States: IDLE, ADVANCE, SETTLE, PUBLISH.
- **IDLE:**
  - sample_ready=1.
  - When sample_valid & sample_ready: register sample_in into sfft_sample, increment fill_cnt (saturating at NFFT) and hop_cnt, then go to ADVANCE.
- **ADVANCE:**
  - sfft_advance=1 for exactly this one cycle.
  - Load settle_cnt=SETTLE_CYCLES-1 and go to SETTLE.
- **SETTLE:**
  - Decrement settle_cnt to 0.
  - Leave only when settle_cnt==0 and sfft_output_valid==1.
  - On exit, if fill_cnt==NFFT and hop_cnt==HOP: clear hop_cnt and go to PUBLISH. Otherwise go to IDLE.
  - hop_cnt is also cleared without publishing while fill_cnt<NFFT, so the first frame is published on sample NFFT.
- **PUBLISH:**
  - frame_valid=1.
  - When frame_ready: increment frame_index (16'hFFFF wraps to 0) and go to IDLE.
  - Input stalls (sample_ready=0) until the frame is accepted.
- sfft_sample holds its value from acceptance until the next accepted sample, so it is stable before, during and after the advance pulse.
- Reset (any state, including mid-SETTLE or mid-PUBLISH):
  - state=IDLE.
  - fill_cnt=hop_cnt=settle_cnt=0.
  - sfft_sample=0, sfft_advance=0, frame_valid=0, frame_index=0, timeout_err=0.
  - sample_ready is 1 immediately, since it is combinational from the IDLE state.
  - The SFFT pipeline is reset by the same signal.

## Timing
- sample_ready, frame_valid and sfft_advance are decoded from registered state and have no combinational path from inputs.
- Sample accepted at edge N → sfft_advance high for cycle N+1 → SETTLE begins at N+2.
- Earliest return to IDLE is edge N+1+SETTLE_CYCLES when sfft_output_valid is already high. Minimum sample period is therefore SETTLE_CYCLES+2 cycles when no frame is published.
- frame_valid rises at the edge leaving SETTLE.
- frame_valid & frame_ready in the same cycle completes the transfer, even when frame_ready was already high when frame_valid rose. Minimum PUBLISH dwell is 1 cycle.
- sample_valid asserted outside IDLE is ignored, not lost. The source must hold it.
- A low sfft_output_valid at settle_cnt==0 extends SETTLE indefinitely; the watchdog applies when enabled.

## Configuration
- SFFT_SEQ_TIMEOUT_EN defined:
  - A watchdog counter runs in SETTLE.
  - If TIMEOUT_CYCLES cycles elapse in SETTLE without exit: set timeout_err (sticky until reset) and go to IDLE without publishing. hop_cnt is left unchanged.
- Undefined: no watchdog; timeout_err tied 0.

## Test plan
- **Reset:**
  - Check: after reset, sample_ready=1 and all other outputs 0.
  - Assert reset mid-SETTLE → state returns to IDLE and sfft_advance=0 within the same cycle (asynchronous).
- **Single sample:**
  - Stimulus: sample_in=61 with valid held high; sfft_output_valid held high.
  - Required: sfft_sample=61 the next cycle, exactly one sfft_advance pulse, sample_ready low for SETTLE_CYCLES+1 cycles, no frame_valid.
- **Window fill:**
  - Stimulus: samples 61, 77, 90, 6, 33, 23, 85, 11 with HOP=4.
  - Required: exactly one frame_valid, after the 8th sample. frame_index becomes 1 after frame_ready.
- **Hop and backpressure:**
  - Stimulus: 4 more samples; frame_ready held low for 20 cycles.
  - Required: frame_valid held for 20 cycles, sample_ready stays 0, then frame_index=2.
- **Settle wait:**
  - Stimulus: drop sfft_output_valid for 50 cycles after an advance.
  - Required: SETTLE is held for 50 cycles, then exits the cycle after valid returns.
- **Watchdog (SFFT_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=255):**
  - Stimulus: hold sfft_output_valid=0.
  - Required: timeout_err=1 after 255 SETTLE cycles, state returns to IDLE, and the error stays set across later samples until reset.
